// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box table and lookup, schedule length, scheduler state encoding.
package present_pkg;

    localparam int unsigned NUM_KEYS = 32;

    // 16x4 S-box table packed as nibbles; nibble n holds S(n).
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] nib);
        return SBOX_TABLE[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_sbox4.sv
// 4-bit combinational PRESENT S-box lookup built on the shared package table.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = sbox4(nib_i);

endmodule

// File: rtl/present_key_sched.sv
// Iterative PRESENT-80/128 round-key generator: one 64-bit round key per valid/ready handshake,
// K1..K(NUM_ROUNDS+1), with a one-cycle done pulse after the final key is accepted.
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_LEN    = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic [KEY_LEN-1:0] key_in,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [63:0]        rk_data,
    output logic [5:0]         rk_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS + 1);

    state_e             state_q, state_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic [KEY_LEN-1:0] key_rot_s, key_upd_s;
    logic [5:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Rotate left by 61; the S-box and counter XOR then act on the rotated value.
    assign key_rot_s = {key_q[KEY_LEN-62:0], key_q[KEY_LEN-1:KEY_LEN-61]};

    generate
        if (KEY_LEN == 80) begin : g_k80
            logic [3:0] sb_hi_s;

            present_sbox4 u_sbox_hi (.nib_i(key_rot_s[79:76]), .nib_o(sb_hi_s));

            // 80-bit update: one S-box on the top nibble, counter into bits 19:15.
            always_comb begin
                key_upd_s        = key_rot_s;
                key_upd_s[79:76] = sb_hi_s;
                key_upd_s[19:15] = key_rot_s[19:15] ^ idx_q[4:0];
            end
        end else if (KEY_LEN == 128) begin : g_k128
            logic [3:0] sb_hi_s;
            logic [3:0] sb_lo_s;

            present_sbox4 u_sbox_hi (.nib_i(key_rot_s[127:124]), .nib_o(sb_hi_s));
            present_sbox4 u_sbox_lo (.nib_i(key_rot_s[123:120]), .nib_o(sb_lo_s));

            // 128-bit update: S-box on the top two nibbles, counter into bits 66:62.
            always_comb begin
                key_upd_s          = key_rot_s;
                key_upd_s[127:124] = sb_hi_s;
                key_upd_s[123:120] = sb_lo_s;
                key_upd_s[66:62]   = key_rot_s[66:62] ^ idx_q[4:0];
            end
        end else begin : g_bad_key_len
            $error("present_key_sched: KEY_LEN must be 80 or 128");
            assign key_upd_s = '0;
        end
    endgenerate

    // Next-state logic: a load always wins, otherwise advance on handshake while running.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (key_load) begin
            state_d = RUN;
            key_d   = key_in;
            idx_d   = 6'd1;
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
                RUN: begin
                    if (rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = 6'd0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            key_d = key_upd_s;
                            idx_d = idx_q + 6'd1;
                        end
                    end else begin
                        key_d = key_q;
                        idx_d = idx_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 6'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = valid_q;
    assign rk_data  = key_q[KEY_LEN-1 -: 64];
    assign rk_idx   = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
